cla_adder_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control. It is the next-generation datapath adder for the arithmetic blocks. It generalises the fixed 8-bit combinational CLA to WIDTH bits with two-level (bit/group) lookahead, a subtract mode, and backpressure-safe pipelining so it can sit between registered producers and consumers at full throughput.

---
 rtl/cla_adder_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_cla_adder_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow
// control.
//
//   {cout,sum} = a + (b ^ {WIDTH{sub}}) + (cin ^ sub)
//
// Stage 1 registers the per-bit propagate/generate terms, the per-group
// propagate/generate terms and the effective carry-in. Stage 2 resolves group
// carries with a second-level lookahead (no ripple between groups), derives bit
// carries with in-group lookahead and registers the result.
//
// Parameters:
//   WIDTH      operand/result width, multiple of GROUP, 4..64
//   GROUP      bits per first-level lookahead group (2, 4 or 8)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle
//   a, b       operands
//   cin        carry-in (borrow-in when sub=1)
//   sub        0 = add, 1 = subtract
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result (modulo 2^WIDTH)
//   cout       carry-out (in subtract mode 1 = no borrow)
//   ovf        signed overflow, only when CLA_OVF_EN is defined
//
// Build option:
//   CLA_OVF_EN  adds the registered signed-overflow output ovf.
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NG = WIDTH / GROUP;

    // Carry into bit position k of a GROUP-wide slice, written as the flat
    // sum-of-products lookahead: ci*p[0..k-1] + sum_j g[j]*p[j+1..k-1].
    // With ci=0 and k=GROUP this is the group generate term.
    function automatic logic bit_la(input logic [GROUP-1:0] gv,
                                    input logic [GROUP-1:0] pv,
                                    input logic             ci,
                                    input int unsigned      k);
        logic res;
        logic prod;
        res = ci;
        for (int unsigned m = 0; m < k; m++) begin
            res = res & pv[m];
        end
        for (int unsigned j = 0; j < k; j++) begin
            prod = gv[j];
            for (int unsigned m = j + 1; m < k; m++) begin
                prod = prod & pv[m];
            end
            res = res | prod;
        end
        return res;
    endfunction

    // Same lookahead form applied across groups: carry into group k.
    function automatic logic grp_la(input logic [NG-1:0] gv,
                                    input logic [NG-1:0] pv,
                                    input logic          ci,
                                    input int unsigned   k);
        logic res;
        logic prod;
        res = ci;
        for (int unsigned m = 0; m < k; m++) begin
            res = res & pv[m];
        end
        for (int unsigned j = 0; j < k; j++) begin
            prod = gv[j];
            for (int unsigned m = j + 1; m < k; m++) begin
                prod = prod & pv[m];
            end
            res = res | prod;
        end
        return res;
    endfunction

    // ---------------------------------------------------------------------
    // Flow control
    // ---------------------------------------------------------------------
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv;

    // ---------------------------------------------------------------------
    // Stage 1: bit and group propagate/generate
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] p_d;
    logic [WIDTH-1:0] g_d;
    logic [NG-1:0]    gp_d;
    logic [NG-1:0]    gg_d;
    logic             ci_d;

    always_comb begin
        b_eff = b ^ {WIDTH{sub}};
        p_d   = a ^ b_eff;
        g_d   = a & b_eff;
        ci_d  = cin ^ sub;
        gp_d  = '0;
        gg_d  = '0;
        for (int unsigned k = 0; k < NG; k++) begin
            gp_d[k] = &p_d[k*GROUP +: GROUP];
            gg_d[k] = bit_la(g_d[k*GROUP +: GROUP], p_d[k*GROUP +: GROUP], 1'b0, GROUP);
        end
    end

    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic [NG-1:0]    gp_q;
    logic [NG-1:0]    gg_q;
    logic             ci_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            p_q        <= '0;
            g_q        <= '0;
            gp_q       <= '0;
            gg_q       <= '0;
            ci_q       <= 1'b0;
        end else if (s1_adv) begin
            // Advancing without a new input leaves a bubble in stage 1.
            s1_valid_q <= in_valid;
            if (in_valid) begin
                p_q  <= p_d;
                g_q  <= g_d;
                gp_q <= gp_d;
                gg_q <= gg_d;
                ci_q <= ci_d;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage 2: group carries, bit carries, result
    // ---------------------------------------------------------------------
    logic [NG:0]      gc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    always_comb begin
        gc = '0;
        c  = '0;
        for (int unsigned k = 0; k <= NG; k++) begin
            gc[k] = grp_la(gg_q, gp_q, ci_q, k);
        end
        for (int unsigned k = 0; k < NG; k++) begin
            for (int unsigned i = 0; i < GROUP; i++) begin
                c[k*GROUP + i] = bit_la(g_q[k*GROUP +: GROUP], p_q[k*GROUP +: GROUP], gc[k], i);
            end
        end
        c[WIDTH] = gc[NG];
        sum_d    = p_q ^ c[WIDTH-1:0];
        cout_d   = c[WIDTH];
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

`ifdef CLA_OVF_EN
    logic ovf_d;
    logic ovf_q;

    assign ovf_d = c[WIDTH] ^ c[WIDTH-1];
    assign ovf   = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s2_adv && s1_valid_q) begin
            ovf_q <= ovf_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid_q;
            // Result registers only move when real data arrives, so they
            // stay quiet across bubbles.
            if (s1_valid_q) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_pipe
//
// Self-checking bench for cla_adder_pipe (WIDTH=16, GROUP=4). A reference
// model computes each accepted transaction with plain integer arithmetic; a
// monitor compares every delivered result against it in order, checks latency
// and hold-under-stall. Directed vectors carry hand-computed expectations.
// Define CLA_OVF_EN to also exercise the overflow output.
// -----------------------------------------------------------------------------
module tb_cla_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
`ifdef CLA_OVF_EN
    logic        ovf;
`endif

    cla_adder_pipe #(
        .WIDTH(16),
        .GROUP(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout)
`ifdef CLA_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;
    int out_cnt = 0;
    bit lat_strict = 1'b1;

    typedef struct {
        logic [17:0] exp;   // {ovf, cout, sum}
        int          cyc;
        bit          lat;
    } ent_t;
    ent_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: integer add of a, the (possibly inverted) b and the effective
    // carry; signed overflow when like-signed operands give an opposite-sign sum.
    function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                          input logic ci, input logic sb);
        logic [15:0] be;
        logic [16:0] r;
        logic        o;
        be = sb ? ~bv : bv;
        r  = {1'b0, av} + {1'b0, be} + {16'd0, ci ^ sb};
        o  = (av[15] == be[15]) && (r[15] != av[15]);
        return {o, r};
    endfunction

    // Monitor: scoreboard compare, latency, stall stability.
    bit          hold = 1'b0;
    logic [15:0] hsum;
    logic        hcout;

    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(sum), 32'(hsum));
                chk("hold_cout", 32'(cout), 32'(hcout));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 32'(q.size()), 32'd1);
                end else begin
                    chk("sb_sum", 32'(sum), 32'(q[0].exp[15:0]));
                    chk("sb_cout", 32'(cout), 32'(q[0].exp[16]));
`ifdef CLA_OVF_EN
                    chk("sb_ovf", 32'(ovf), 32'(q[0].exp[17]));
`endif
                    if (q[0].lat)
                        chk("sb_latency", 32'(cyc - q[0].cyc), 32'd2);
                    if (out_ready) begin
                        void'(q.pop_front());
                        out_cnt++;
                    end
                end
            end
            hold  = out_valid && !out_ready;
            hsum  = sum;
            hcout = cout;
            if (in_valid && in_ready) begin
                q.push_back('{exp: model(a, b, cin, sub), cyc: cyc, lat: lat_strict});
                acc_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction on an empty pipe with out_ready high.
    task automatic dir(input string nm, input logic [15:0] av, input logic [15:0] bv,
                       input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
        logic [17:0] m;
        m = model(av, bv, ci, sb);
        chk({nm, "_model_sum"}, 32'(m[15:0]), 32'(es));
        chk({nm, "_model_cout"}, 32'(m[16]), 32'(ec));
        chk({nm, "_model_ovf"}, 32'(m[17]), 32'(eo));
        a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        a = 16'h0; b = 16'h0;
        chk({nm, "_valid_c1"}, 32'(out_valid), 32'd0);
        step();
        chk({nm, "_valid_c2"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
`ifdef CLA_OVF_EN
        chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`endif
        step();
    endtask

    task automatic rand_ops();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
        int a0;
        int o0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef CLA_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        dir("add_carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        dir("sub_borrow",      16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        dir("sub_borrow_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        dir("add_pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        dir("sub_neg_ovf",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        dir("add_small",       16'h0003, 16'h0002, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
        dir("sub_zero",        16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        dir("add_cin_wrap",    16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);

        // Streaming, out_ready held high
        lat_strict = 1'b1;
        o0 = out_cnt;
        for (int i = 0; i < 100; i++) begin
            rand_ops();
            in_valid = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();
        chk("stream_count", 32'(out_cnt - o0), 32'd100);
        chk("stream_drained", 32'(q.size()), 32'd0);

        // Backpressure from an empty pipe
        lat_strict = 1'b0;
        a0 = acc_cnt;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
        end
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rand_ops();
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        chk("bp_drained", 32'(q.size()), 32'd0);
        chk("bp_no_loss", 32'(out_cnt), 32'(acc_cnt));

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_ops();
        step();
        rand_ops();
        step();
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sum", 32'(sum), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        q.delete();
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_idle", 32'(out_valid), 32'd0);
        lat_strict = 1'b1;
        dir("post_rst_add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        dir("post_rst_sub", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0);
        repeat (2) step();
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
